hex_seg_decoder: RTL and testbench

- Inverse of the board's nibble-to-seven-segment encoders. Samples one active-low 8-bit HEX bus (bit7 = dp, bit6..0 = g..a).
- Filters the bus for stability and decodes it back to a 4-bit value plus a symbol class.
- Hands each newly stable pattern downstream over a valid/ready handshake.
- Used as an on-chip readback/self-check of the display path, and as a bench monitor for Unit-level display outputs.

---
 rtl/seg_codes_pkg.sv | 40 ++++
 rtl/seg_pattern_lut.sv | 37 +++
 rtl/hex_seg_decoder.sv | 103 ++++++++++
 tb/tb_hex_seg_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_codes_pkg.sv
// Shared seven-segment codes (active-low, g..a in bits 6..0), symbol classes
// and the handshake FSM encoding for the HEX readback decoder.
package seg_codes_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] KIND_DIGIT   = 2'b00;
  localparam logic [1:0] KIND_L       = 2'b01;
  localparam logic [1:0] KIND_BLANK   = 2'b10;
  localparam logic [1:0] KIND_INVALID = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  typedef struct packed {
    logic [7:0] raw;
    logic [3:0] nibble;
    logic [1:0] kind;
    logic       dp;
  } seg_result_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational segment-pattern classifier: g..a bits to nibble and symbol class.
module seg_pattern_lut
  import seg_codes_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] nibble,
  output logic [1:0] kind
);

  always_comb begin
    nibble = 4'h0;
    kind   = KIND_DIGIT;
    case (segs)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      // The letter 'E' shares this pattern; it always reads back as digit E.
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_L:     kind = KIND_L;
      SEG_BLANK: kind = KIND_BLANK;
      default:   kind = KIND_INVALID;
    endcase
  end

endmodule

// File: rtl/hex_seg_decoder.sv
// Stability-filtered readback of an active-low HEX display bus; each new
// stable pattern is decoded and offered once over a valid/ready handshake.
module hex_seg_decoder
  import seg_codes_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] HEX_IN,
  input  logic       OUT_READY,
  output logic       OUT_VALID,
  output logic [3:0] NIBBLE,
  output logic [1:0] KIND,
  output logic       DP,
  output logic [7:0] RAW,
  output logic       OVERRUN
);

  // Handshake: a result transfers on a rising edge where OUT_VALID and
  // OUT_READY are both high; OUT_VALID never waits on OUT_READY, and the
  // result holds until transfer unless a newer pattern overwrites it.

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [7:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       last_q, last_d;
  logic             last_vld_q, last_vld_d;
  logic [0:0]       state_q, state_d;
  seg_result_t      res_q, res_d;
  logic             ovr_q, ovr_d;
  logic             qualify;
  logic [3:0]       lut_nibble;
  logic [1:0]       lut_kind;

  seg_pattern_lut u_lut (
    .segs   (s_q[6:0]),
    .nibble (lut_nibble),
    .kind   (lut_kind)
  );

  always_comb begin
    s_d = HEX_IN;
    if (HEX_IN != s_q)
      cnt_d = '0;
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    // Qualify on the edge the counter reaches its limit, so the result is
    // visible right after edge STABLE_CYCLES+1 of the new value.
    qualify = (cnt_d == CNT_MAX) && (!last_vld_q || (s_q != last_q));

    last_d     = last_q;
    last_vld_d = last_vld_q;
    res_d      = res_q;
    ovr_d      = ovr_q;
    state_d    = state_q;

    if (qualify) begin
      last_d     = s_q;
      last_vld_d = 1'b1;
      res_d      = '{raw: s_q, nibble: lut_nibble, kind: lut_kind, dp: ~s_q[7]};
      state_d    = ST_VALID;
      if ((state_q == ST_VALID) && !OUT_READY)
        ovr_d = 1'b1;
    end else if ((state_q == ST_VALID) && OUT_READY) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q        <= 8'hFF;
      cnt_q      <= '0;
      last_q     <= 8'hFF;
      last_vld_q <= 1'b0;
      state_q    <= ST_IDLE;
      res_q      <= '{raw: 8'hFF, nibble: 4'h0, kind: KIND_BLANK, dp: 1'b0};
      ovr_q      <= 1'b0;
    end else begin
      s_q        <= s_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      state_q    <= state_d;
      res_q      <= res_d;
      ovr_q      <= ovr_d;
    end
  end

  assign OUT_VALID = (state_q == ST_VALID);
  assign NIBBLE    = res_q.nibble;
  assign KIND      = res_q.kind;
  assign DP        = res_q.dp;
  assign RAW       = res_q.raw;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_hex_seg_decoder.sv
// Randomised and directed bench for hex_seg_decoder with a stable-run
// reference model feeding an expected-result queue.
module tb_hex_seg_decoder;

  localparam int STABLE = 4;
  localparam logic [7:0] DIGIT_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hex_in = 8'hFF;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [3:0] nibble;
  logic [1:0] kind;
  logic       dp;
  logic [7:0] raw;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  hex_seg_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .CLK       (clk),
    .RST       (rst),
    .HEX_IN    (hex_in),
    .OUT_READY (out_ready),
    .OUT_VALID (out_valid),
    .NIBBLE    (nibble),
    .KIND      (kind),
    .DP        (dp),
    .RAW       (raw),
    .OVERRUN   (overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [7:0] p, output logic [3:0] nib,
                                     output logic [1:0] k, output logic d);
    nib = 4'h0;
    k   = 2'b11;
    d   = (p[7] == 1'b0);
    for (int i = 15; i >= 0; i--) begin
      if (p[6:0] == DIGIT_TAB[i][6:0]) begin
        nib = 4'(i);
        k   = 2'b00;
      end
    end
    if (k == 2'b11) begin
      if (p[6:0] == 7'h47) k = 2'b01;
      else if (p[6:0] == 7'h7F) k = 2'b10;
    end
  endfunction

  // ---------------- reference model ----------------
  // A pattern is accepted on the (STABLE+1)-th consecutive edge that sees it,
  // provided it differs from the last accepted one. The reset edge counts as
  // a sighting of 8'hFF.
  logic [7:0] exp_q[$];
  logic [7:0] cur      = 8'hFF;
  int         run      = 1;
  logic       last_vld = 1'b0;
  logic [7:0] last_raw = 8'hFF;
  logic       m_valid  = 1'b0;
  logic       m_ovr    = 1'b0;

  always @(posedge clk) begin
    logic consumed;
    logic accept;
    if (rst) begin
      cur = 8'hFF; run = 1; last_vld = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      consumed = m_valid && out_ready;
      if (hex_in == cur) begin
        if (run < STABLE + 1) run++;
      end else begin
        cur = hex_in;
        run = 1;
      end
      accept = (run == STABLE + 1) && (!last_vld || (cur != last_raw));
      if (accept) begin
        last_vld = 1'b1;
        last_raw = cur;
        if (m_valid && !consumed) begin
          m_ovr = 1'b1;
          if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = cur;
          else exp_q.push_back(cur);
        end else begin
          exp_q.push_back(cur);
        end
        m_valid = 1'b1;
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [3:0] e_nib;
    logic [1:0] e_kind;
    logic       e_dp;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid_raw", 32'(raw), 32'hFFFF_FFFF);
      end else begin
        ref_decode(exp_q[0], e_nib, e_kind, e_dp);
        check("raw", 32'(raw), 32'(exp_q[0]));
        check("nibble", 32'(nibble), 32'(e_nib));
        check("kind", 32'(kind), 32'(e_kind));
        check("dp", 32'(dp), 32'(e_dp));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    hex_in = v;
    repeat (n) step();
  endtask

  task automatic check_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_nibble", 32'(nibble), 32'h0);
    check("rst_kind", 32'(kind), 32'h2);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_raw", 32'(raw), 32'hFF);
    check("rst_overrun", 32'(overrun), 32'h0);
  endtask

  function automatic logic [7:0] rand_pattern();
    int sel;
    logic [7:0] p;
    sel = $urandom_range(0, 19);
    if (sel < 16) begin
      p = DIGIT_TAB[sel];
      p[7] = $urandom_range(0, 1) != 0;
    end else if (sel == 16) p = 8'hC7;
    else if (sel == 17) p = 8'hFF;
    else if (sel == 18) p = 8'h7E;
    else p = 8'($urandom_range(0, 255));
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; hex_in = 8'hFF; out_ready = 1'b1;
    step(); step();
    check_reset();
    rst = 1'b0;

    // Digit 0, single pulse.
    hold(8'hC0, 10);

    // Same digit with and without dp, then a long re-hold.
    hold(8'h88, 8);
    hold(8'h08, 8);
    hold(8'h08, 20);

    // Glitching bus, then settle on digit 2.
    for (int i = 0; i < 5; i++) begin
      hold(8'hF9, 2);
      hold(8'hA4, 2);
    end
    hold(8'hA4, 10);

    // Overwrite while unacknowledged.
    out_ready = 1'b0;
    hold(8'hC7, 6);
    hold(8'hFF, 6);
    out_ready = 1'b1;
    hold(8'hFF, 4);

    // Invalid pattern, reset mid-VALID, re-emission.
    out_ready = 1'b0;
    hold(8'h7E, 8);
    rst = 1'b1;
    step();
    check_reset();
    rst = 1'b0;
    hold(8'h7E, 8);
    out_ready = 1'b1;
    hold(8'h7E, 4);

    // Random patterns, hold lengths and backpressure.
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      hold(rand_pattern(), $urandom_range(1, 9));
    end

    out_ready = 1'b1;
    hold(hex_in, 12);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
